// File: rtl/p_beid_interconnect_f0_ahb_mtx_input_stage.sv
// Per-master input stage of the f0 AHB bus matrix: forwards or holds the master's
// address phase and routes the serving output stage's ready/response back.
module p_beid_interconnect_f0_ahb_mtx_input_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  active_ip,
  input  logic                  readyout_ip,
  input  logic                  resp_ip,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  sel_op,
  output logic [ADDR_WIDTH-1:0] addr_op,
  output logic [1:0]            trans_op,
  output logic                  write_op,
  output logic [2:0]            size_op,
  output logic [2:0]            burst_op,
  output logic [3:0]            prot_op,
  output logic                  master_lock_op,
  output logic                  held_tran_op
);

  logic                  pend_tran;
  logic                  data_phase;
  logic                  hold_sel;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [1:0]            hold_trans;
  logic                  hold_write;
  logic [2:0]            hold_size;
  logic [2:0]            hold_burst;
  logic [3:0]            hold_prot;
  logic                  hold_lock;

  logic new_tran;
  logic accept;

  assign new_tran = HSELS & HREADYS & HTRANSS[1];
  assign accept   = active_ip & readyout_ip;

  // The holding register can only load while HREADYS is high, so a pending
  // transfer (which forces HREADYS low at the master) is never overwritten.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_tran  <= 1'b0;
      data_phase <= 1'b0;
      hold_sel   <= 1'b0;
      hold_addr  <= '0;
      hold_trans <= 2'b00;
      hold_write <= 1'b0;
      hold_size  <= 3'b000;
      hold_burst <= 3'b000;
      hold_prot  <= 4'b0000;
      hold_lock  <= 1'b0;
    end else begin
      if (HSELS & HREADYS) begin
        hold_sel   <= HSELS;
        hold_addr  <= HADDRS;
        hold_trans <= HTRANSS;
        hold_write <= HWRITES;
        hold_size  <= HSIZES;
        hold_burst <= HBURSTS;
        hold_prot  <= HPROTS;
        hold_lock  <= HMASTLOCKS;
      end

      if (new_tran & ~accept)
        pend_tran <= 1'b1;
      else if (pend_tran & accept)
        pend_tran <= 1'b0;

      // IDLE and BUSY are answered locally and never open a data phase.
      if (accept & sel_op & trans_op[1])
        data_phase <= 1'b1;
      else if (readyout_ip | ~data_phase)
        data_phase <= 1'b0;
    end
  end

  assign sel_op         = pend_tran ? hold_sel   : HSELS;
  assign addr_op        = pend_tran ? hold_addr  : HADDRS;
  assign trans_op       = pend_tran ? hold_trans : HTRANSS;
  assign write_op       = pend_tran ? hold_write : HWRITES;
  assign size_op        = pend_tran ? hold_size  : HSIZES;
  assign burst_op       = pend_tran ? hold_burst : HBURSTS;
  assign prot_op        = pend_tran ? hold_prot  : HPROTS;
  assign master_lock_op = pend_tran ? hold_lock  : HMASTLOCKS;
  assign held_tran_op   = pend_tran;

  assign HREADYOUTS = data_phase ? readyout_ip : ~pend_tran;
  assign HRESPS     = data_phase ? resp_ip : 1'b0;

endmodule

// File: tb/tb_p_beid_interconnect_f0_ahb_mtx_input_stage.sv
// Directed scoreboard bench for the AHB matrix input stage: each step pushes the
// expected master-side response and address presentation, then pops and checks it.
module tb_p_beid_interconnect_f0_ahb_mtx_input_stage;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        HCLK;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        active_ip;
  logic        readyout_ip;
  logic        resp_ip;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        sel_op;
  logic [31:0] addr_op;
  logic [1:0]  trans_op;
  logic        write_op;
  logic [2:0]  size_op;
  logic [2:0]  burst_op;
  logic [3:0]  prot_op;
  logic        master_lock_op;
  logic        held_tran_op;

  typedef struct {
    string       tag;
    logic        ready;
    logic        resp;
    logic        held;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  p_beid_interconnect_f0_ahb_mtx_input_stage #(.ADDR_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_op(sel_op), .addr_op(addr_op),
    .trans_op(trans_op), .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
    .prot_op(prot_op), .master_lock_op(master_lock_op), .held_tran_op(held_tran_op)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic sel, input logic hrdy, input logic [1:0] trans,
                               input logic [31:0] addr, input logic act,
                               input logic rdy, input logic rsp);
    HSELS       = sel;
    HREADYS     = hrdy;
    HTRANSS     = trans;
    HADDRS      = addr;
    active_ip   = act;
    readyout_ip = rdy;
    resp_ip     = rsp;
  endtask

  task automatic expectOut(input string tag, input logic rdy, input logic rsp,
                           input logic held, input logic [31:0] addr);
    exp_t e;
    e.tag = tag; e.ready = rdy; e.resp = rsp; e.held = held; e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, want at least 1");
    end else begin
      e = sb.pop_front();
      total++;
      assert (HREADYOUTS === e.ready) else begin
        bad++;
        $error("[TB] FAIL %s.hready got=%b want=%b", e.tag, HREADYOUTS, e.ready);
      end
      total++;
      assert (HRESPS === e.resp) else begin
        bad++;
        $error("[TB] FAIL %s.hresp got=%b want=%b", e.tag, HRESPS, e.resp);
      end
      total++;
      assert (held_tran_op === e.held) else begin
        bad++;
        $error("[TB] FAIL %s.held got=%b want=%b", e.tag, held_tran_op, e.held);
      end
      total++;
      assert (addr_op === e.addr) else begin
        bad++;
        $error("[TB] FAIL %s.addr got=%h want=%h", e.tag, addr_op, e.addr);
      end
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic runCycle(input string tag, input logic rdy, input logic rsp,
                          input logic held, input logic [31:0] addr);
    expectOut(tag, rdy, rsp, held, addr);
    @(negedge HCLK);
    checkOutput();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn    = 1'b0;
    HWRITES    = 1'b1;
    HSIZES     = 3'b010;
    HBURSTS    = 3'b000;
    HPROTS     = 4'b0011;
    HMASTLOCKS = 1'b0;
    applyStimulus(1'b0, 1'b1, IDLE, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
    expectOut("reset", 1'b1, 1'b0, 1'b0, 32'h0000_1234);
    @(negedge HCLK);
    checkOutput();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Granted single write: forwarded same cycle, data phase next cycle.
    applyStimulus(1'b1, 1'b1, NONSEQ, 32'h2000_0010, 1'b1, 1'b1, 1'b0);
    runCycle("grant_addr", 1'b1, 1'b0, 1'b0, 32'h2000_0010);
    applyStimulus(1'b0, 1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b1);
    runCycle("grant_data", 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b1);
    runCycle("grant_done", 1'b1, 1'b0, 1'b0, 32'h0);

    // Blocked transfer held for 3 cycles while the master's address changes.
    applyStimulus(1'b1, 1'b1, NONSEQ, 32'h2000_0040, 1'b0, 1'b1, 1'b0);
    runCycle("blk_n", 1'b1, 1'b0, 1'b0, 32'h2000_0040);
    applyStimulus(1'b1, 1'b0, NONSEQ, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    runCycle("blk_n1", 1'b0, 1'b0, 1'b1, 32'h2000_0040);
    runCycle("blk_n2", 1'b0, 1'b0, 1'b1, 32'h2000_0040);
    applyStimulus(1'b1, 1'b0, NONSEQ, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    runCycle("blk_n3", 1'b0, 1'b0, 1'b1, 32'h2000_0040);
    applyStimulus(1'b0, 1'b1, IDLE, 32'h0, 1'b0, 1'b0, 1'b0);
    runCycle("blk_n4", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
    runCycle("blk_n5", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, IDLE, 32'h0, 1'b0, 1'b0, 1'b0);
    runCycle("blk_n6", 1'b1, 1'b0, 1'b0, 32'h0);

    // Slave inserts two wait states.
    applyStimulus(1'b1, 1'b1, NONSEQ, 32'h3000_0000, 1'b1, 1'b1, 1'b0);
    runCycle("ws_addr", 1'b1, 1'b0, 1'b0, 32'h3000_0000);
    applyStimulus(1'b0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 1'b0);
    runCycle("ws_wait1", 1'b0, 1'b0, 1'b0, 32'h0);
    runCycle("ws_wait2", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
    runCycle("ws_done", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, IDLE, 32'h0, 1'b0, 1'b0, 1'b0);
    runCycle("ws_cleared", 1'b1, 1'b0, 1'b0, 32'h0);

    // Two-cycle ERROR, then an IDLE gets a zero-wait OKAY.
    applyStimulus(1'b1, 1'b1, NONSEQ, 32'h4000_0000, 1'b1, 1'b1, 1'b0);
    runCycle("err_addr", 1'b1, 1'b0, 1'b0, 32'h4000_0000);
    applyStimulus(1'b0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 1'b1);
    runCycle("err_c1", 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, IDLE, 32'h4000_0100, 1'b1, 1'b1, 1'b1);
    runCycle("err_c2", 1'b1, 1'b1, 1'b0, 32'h4000_0100);
    applyStimulus(1'b1, 1'b1, IDLE, 32'h4000_0100, 1'b1, 1'b0, 1'b1);
    runCycle("err_idle", 1'b1, 1'b0, 1'b0, 32'h4000_0100);

    // BUSY and IDLE never open a data phase or a pending hold.
    applyStimulus(1'b1, 1'b1, BUSY, 32'h4000_0200, 1'b1, 1'b1, 1'b0);
    runCycle("busy_acc", 1'b1, 1'b0, 1'b0, 32'h4000_0200);
    applyStimulus(1'b1, 1'b1, IDLE, 32'h4000_0300, 1'b0, 1'b0, 1'b1);
    runCycle("busy_after", 1'b1, 1'b0, 1'b0, 32'h4000_0300);
    applyStimulus(1'b1, 1'b1, BUSY, 32'h4000_0400, 1'b0, 1'b1, 1'b0);
    runCycle("busy_blk", 1'b1, 1'b0, 1'b0, 32'h4000_0400);
    applyStimulus(1'b1, 1'b1, IDLE, 32'h4000_0500, 1'b0, 1'b1, 1'b1);
    runCycle("busy_nopend", 1'b1, 1'b0, 1'b0, 32'h4000_0500);

    // Asynchronous reset while a transfer is pending.
    applyStimulus(1'b1, 1'b1, NONSEQ, 32'h5000_0000, 1'b0, 1'b1, 1'b0);
    runCycle("rst_blk", 1'b1, 1'b0, 1'b0, 32'h5000_0000);
    applyStimulus(1'b1, 1'b0, NONSEQ, 32'h0BAD_0000, 1'b0, 1'b1, 1'b0);
    expectOut("rst_pend", 1'b0, 1'b0, 1'b1, 32'h5000_0000);
    @(negedge HCLK);
    checkOutput();
    #2;
    HRESETn = 1'b0;
    #1;
    expectOut("rst_async", 1'b1, 1'b0, 1'b0, 32'h0BAD_0000);
    checkOutput();
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    applyStimulus(1'b1, 1'b1, NONSEQ, 32'h6000_0000, 1'b1, 1'b1, 1'b0);
    runCycle("rst_after", 1'b1, 1'b0, 1'b0, 32'h6000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p_beid_interconnect_f0_ahb_mtx_input_stage.md
# p_beid_interconnect_f0_ahb_mtx_input_stage

Per-master input stage of the f0 AHB bus matrix. It sits between one master-side AHB port and that port's decoder and output-stage arbiters. It presents the master's address phase to the matrix. When the target output stage does not grant the port in the same cycle, it holds the transfer in a register and stalls the master with HREADYOUTS low until the transfer is taken. It then routes the slave's data-phase ready and response back to the master.

## Interface
- ADDR_WIDTH, 32, address bus width.
- HCLK  input  1  AHB system clock.
- HRESETn  input  1  reset, asynchronous, active-low.
- HSELS  input  1  port select from the master side.
- HADDRS  input  ADDR_WIDTH  address.
- HTRANSS  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITES  input  1  write.
- HSIZES  input  3  size.
- HBURSTS  input  3  burst type.
- HPROTS  input  4  protection.
- HMASTLOCKS  input  1  locked transfer.
- HREADYS  input  1  HREADY seen by the master (address-phase qualifier).
- active_ip  input  1  an output stage has this port as its addr_in_port this cycle and no_port is low.
- readyout_ip  input  1  HREADY from the output stage currently serving this port.
- resp_ip  input  1  HRESP from the output stage serving this port's data phase.
- HREADYOUTS  output  1  ready returned to the master.
- HRESPS  output  1  response returned to the master.
- sel_op, addr_op[ADDR_WIDTH-1:0], trans_op[1:0], write_op, size_op[2:0], burst_op[2:0], prot_op[3:0], master_lock_op  output  —  address phase presented to the decoder, arbiters and output stages.
- held_tran_op  output  1  the address phase on the *_op outputs comes from the holding register.

## Operation
- Definitions:
  - new_tran = HSELS & HREADYS & HTRANSS[1].
  - accept = active_ip & readyout_ip.
- Holding register:
  - Loads all address-phase inputs when HSELS & HREADYS.
  - Keeps its value otherwise.
- pend_tran:
  - Sets when new_tran & ~accept.
  - Clears when pend_tran & accept.
  - If both conditions are true in the same cycle (a held transfer is accepted while a new transfer arrives and is not accepted), pend_tran stays 1 and the register loads the new transfer. This cannot occur while HREADYOUTS=0 because HREADYS is low; it is defined only for robustness.
- *_op mux:
  - pend_tran=1: drive the holding register.
  - pend_tran=0: drive the live inputs combinationally.
  - held_tran_op = pend_tran.
- data_phase flag:
  - Next value is 1 when accept & sel_op & trans_op[1].
  - Next value is 0 otherwise, whenever readyout_ip=1 or data_phase=0.
  - Holds while readyout_ip=0.
  - IDLE and BUSY never enter data_phase. They get a zero-wait OKAY.
- Master response:
  - HREADYOUTS = data_phase ? readyout_ip : ~pend_tran.
  - HRESPS = data_phase ? resp_ip : 0.
- Two-cycle ERROR from the slave passes through unchanged: cycle 1 is HREADYOUTS=0 with HRESPS=1, cycle 2 is HREADYOUTS=1 with HRESPS=1.
- A new transfer cannot be captured during a stalled data phase, since HREADYS is low. The holding register therefore never overwrites a pending transfer.
- master_lock_op follows the same mux. The arbiter keeps the lock grant through the holding path.

## Timing
- Reset (async): pend_tran=0, data_phase=0, holding register=0, HREADYOUTS=1, HRESPS=0, held_tran_op=0. *_op follow the live inputs.
- Reset mid-transfer clears pend_tran and data_phase immediately, without waiting for a clock edge. Any pending transfer is discarded.
- Zero-latency path: a live transfer with accept in the same cycle is forwarded combinationally. data_phase=1 on the next edge. No pend cycle occurs.
- Held path:
  - Cycle N: new_tran with active_ip=0.
  - N+1 onwards: HREADYOUTS=0, held_tran_op=1.
  - First cycle M with accept: pend clears at M+1 and data_phase=1 at M+1.
  - Master sees HREADYOUTS=readyout_ip from M+1.
- Minimum stall on the held path: 1 wait state plus the slave's wait states.
- All state updates occur on the HCLK rising edge.

## Test plan
- Granted single write: HSELS=1, NONSEQ, HADDRS=0x2000_0010, active_ip=1, readyout_ip=1 -> addr_op=0x2000_0010 in the same cycle, held_tran_op=0, next cycle data_phase=1, HREADYOUTS=readyout_ip.
- Blocked transfer: NONSEQ to 0x2000_0040 with active_ip=0 for 3 cycles, then active_ip=1 -> HREADYOUTS=0 for cycles N+1..N+3 and held_tran_op=1 with addr_op=0x2000_0040 over the same cycles, even though HADDRS changes to 0xDEAD_BEEF; held_tran_op falls at N+4 (pend clears at M+1 with M=N+3), then HREADYOUTS=readyout_ip.
- Slave wait states: accepted transfer, readyout_ip low for 2 cycles -> HREADYOUTS=0 for 2 cycles, then 1; data_phase clears.
- ERROR: resp_ip=1 with readyout_ip 0 then 1 -> HRESPS=1 for both cycles, HREADYOUTS 0 then 1; IDLE in the following address phase gives an OKAY zero-wait response.
- IDLE/BUSY while selected: HTRANSS=00 and 01 with active_ip=1 -> HREADYOUTS=1, HRESPS=0, data_phase stays 0, pend_tran stays 0.
- Async reset asserted while pend_tran=1 -> held_tran_op=0 and HREADYOUTS=1 immediately, without a clock edge; after release, *_op equal the live inputs.
